imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have this parameter: MEM_WORDS, default 64, instruction-memory depth in 32-bit words.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 Port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 Port start, input, 1 bit: request to begin a program load.
REQ-005 Port byte_valid, input, 1 bit: byte_data holds a valid byte.
REQ-006 Port byte_data, input, 8 bits: loader stream byte.
REQ-007 Port byte_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-008 Port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-009 Port mem_waddr, output, 6 bits: word index to write.
REQ-010 Port mem_wdata, output, 32 bits: word to write.
REQ-011 Port cpu_hold, output, 1 bit: the processor shall stall and hold its PC at 0 while this is high.
REQ-012 Port busy, output, 1 bit: a load is in progress.
REQ-013 Port load_done, output, 1 bit: the last load completed with a correct checksum.
REQ-014 Port load_err, output, 1 bit: the last load failed its checksum.

Function
REQ-015 A byte SHALL be accepted only on a cycle where byte_valid=1 and byte_ready=1.
REQ-016 The FSM SHALL have these states: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
REQ-017 Transition from IDLE, DONE or ERR: start=1 SHALL go to LEN and clear the word counter, byte counter and checksum.
REQ-018 start SHALL be ignored in LEN, DATA, WRITE and CSUM.
REQ-019 In LEN, an accepted byte SHALL set the word count N = byte_data, with 0 meaning MEM_WORDS; values above MEM_WORDS SHALL saturate to MEM_WORDS; the next state SHALL be DATA.
REQ-020 In DATA, accepted byte k (k = 0..3 within a word) SHALL be stored to word bits [8k+7:8k], little-endian, and XORed into the checksum.
REQ-021 After byte k=3 is accepted, the next state SHALL be WRITE.
REQ-022 WRITE SHALL last exactly one cycle, with these outputs:
- mem_we=1;
- mem_waddr = word counter;
- mem_wdata = the assembled word.
REQ-023 After WRITE, the word counter SHALL increment, and the next state SHALL be CSUM if N words have been written, otherwise DATA.
REQ-024 byte_ready SHALL be 1 only in LEN, DATA and CSUM; in WRITE it SHALL be 0.
REQ-025 Latency: the write strobe SHALL occur exactly one cycle after the 4th byte of a word is accepted.
REQ-026 In CSUM, the accepted byte SHALL be compared with the XOR of all data bytes: equal goes to DONE, unequal goes to ERR.
REQ-027 busy=1 SHALL hold in LEN, DATA, WRITE and CSUM.
REQ-028 cpu_hold=1 SHALL hold in LEN, DATA, WRITE, CSUM and ERR.
REQ-029 cpu_hold=0 SHALL hold in IDLE and DONE.
REQ-030 load_done=1 SHALL hold only in DONE, and load_err=1 only in ERR; both are levels held until the next start.
REQ-031 mem_we SHALL be 0 in every state except WRITE.
REQ-032 mem_waddr and mem_wdata SHALL be don't-care when mem_we=0.
REQ-033 Word-counter wrap: with N=MEM_WORDS, the last write SHALL go to index 63 and the counter SHALL NOT write index 0 again.
REQ-034 byte_valid held high in WRITE SHALL NOT consume the byte; that byte is accepted in the following cycle.
REQ-035 Bytes presented in IDLE, DONE or ERR SHALL be ignored (byte_ready=0).

Reset
REQ-036 reset_n=0 SHALL immediately force these values, regardless of clk:
- state IDLE;
- all counters and the checksum 0;
- mem_we=0, byte_ready=0, busy=0, load_done=0, load_err=0;
- cpu_hold=0.
REQ-037 Reset asserted mid-load SHALL abort the load with no further memory writes.
REQ-038 After reset, words already written SHALL remain as written.
REQ-039 On release of reset_n, the block SHALL be in IDLE and SHALL require start to load.

Verification
REQ-040 Single-word load, stream 01, 00, 10, 80, E2, 72 -> one mem_we pulse with waddr=0 and wdata=E2801000, then load_done=1, cpu_hold=0.
REQ-041 Same stream with checksum byte 73 -> mem_we pulse as above, then load_err=1 and cpu_hold stays 1; a later start -> LEN with load_err=0.
REQ-042 Length byte 00, 256 bytes, each word's four bytes XOR to 00 (checksum 00) -> 64 writes at waddr 0..63 in order, no write to 0 after 63, load_done=1.
REQ-043 byte_valid held continuously at 1 -> byte_ready=0 on every WRITE cycle and no byte lost: data matches the stream exactly.
REQ-044 reset_n pulsed low after 2 of 3 words -> outputs at reset values immediately, no more mem_we, state IDLE.
REQ-045 start pulsed during DATA -> no effect: counters continue and the load completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into instruction memory while holding the CPU.
// Each word is written one cycle after its 4th byte is accepted; byte_ready drops during that write cycle.
module imem_loader #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [5:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  // One extra bit so a full-depth count (MEM_WORDS) is representable.
  localparam int CW = $clog2(MEM_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  nwords_q, nwords_d;
  logic [CW-1:0]  wcnt_q, wcnt_d;
  logic [1:0]     bcnt_q, bcnt_d;
  logic [31:0]    word_q, word_d;
  logic [7:0]     csum_q, csum_d;
  logic           accept;
  logic [CW-1:0]  len_sat;
  logic [CW-1:0]  wcnt_inc;

  assign accept   = byte_valid && byte_ready;
  assign wcnt_inc = wcnt_q + CW'(1);

  // Length byte 0 means a full memory; oversize lengths clamp to the memory depth.
  always_comb begin
    len_sat = CW'(MEM_WORDS);
    if (byte_data != 8'd0 && {24'd0, byte_data} <= 32'(MEM_WORDS)) begin
      len_sat = CW'(byte_data);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      nwords_q <= '0;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
      word_q   <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      csum_q   <= csum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    nwords_d   = nwords_q;
    wcnt_d     = wcnt_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    load_err   = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        load_done = (state_q == DONE);
        load_err  = (state_q == ERR);
        cpu_hold  = (state_q == ERR);
        if (start) begin
          state_d = LEN;
          wcnt_d  = '0;
          bcnt_d  = '0;
          csum_d  = '0;
        end
      end
      LEN: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        if (accept) begin
          nwords_d = len_sat;
          state_d  = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        if (accept) begin
          word_d[{bcnt_q, 3'b000} +: 8] = byte_data;
          csum_d = csum_q ^ byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        mem_we   = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        wcnt_d   = wcnt_inc;
        state_d  = (wcnt_inc == nwords_q) ? CSUM : DATA;
      end
      CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        if (accept) begin
          state_d = (byte_data == csum_q) ? DONE : ERR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_waddr = 6'(wcnt_q);
  assign mem_wdata = word_q;

endmodule
